cdb_slot_arbiter: RTL and testbench
===================================

# cdb_slot_arbiter

Issue-side controller for the common data bus (CDB). It decides each cycle which functional-unit queues (int, div, mult, mem) may issue, so that no two results ever reach the CDB in the same cycle. It also generates the one-hot CDB result-mux select from a slot-reservation shift register, which replaces per-unit enable propagation chains. It sits between the per-unit issue-ready signals and the functional unit group / CDB mux.

## Interface
Parameters:
- `INT_LAT`, 0: cycles from int grant to its CDB cycle.
- `MEM_LAT`, 0: cycles from mem grant to its CDB cycle.
- `MULT_LAT`, 3: cycles from mult grant to its CDB cycle.
- `DIV_LAT`, 6: cycles from div grant to its CDB cycle. The divider is non-pipelined.
- `SLOT_DEPTH`, 8: reservation slots. Every `*_LAT` must be less than `SLOT_DEPTH`.

Ports:
- `i_clk` in 1: clock. Single clock domain; everything on its rising edge.
- `i_rst` in 1: reset. Synchronous, active-high.
- `i_ready_int`, `i_ready_div`, `i_ready_mult`, `i_ready_mem` in 1 each: the unit's issue queue holds an issuable entry.
- `o_issue_int`, `o_issue_div`, `o_issue_mult`, `o_issue_mem` out 1 each: grant, combinational, same cycle as ready.
- `o_cdb_sel` out 4: one-hot CDB mux select, ordered {mem, mult, div, int}.
- `o_div_busy` out 1: divider occupied.
- `o_slot_vld` out SLOT_DEPTH: reservation valid bits, for debug and coverage.

## Operation
State:
- Slot register S[SLOT_DEPTH]. Each entry is {vld, owner}; owner codes are int=0, div=1, mult=2, mem=3. S[k].vld means the CDB is taken k cycles from now.
- Div countdown counter DC.
- Round-robin bit RR: 0 means int is preferred, 1 means mem is preferred.

A unit is eligible when:
- its ready input is 1,
- S[its LAT].vld is 0,
- for div only, DC is 0,
- `i_rst` is 0.

Arbitration among eligible units whose LAT values are equal (a same-slot collision):
- Priority order is div, then mult, then int/mem.
- Between int and mem, RR decides.
- Units with distinct LAT values never conflict, so all of them may be granted in the same cycle.

RR update:
- RR changes only in a cycle where int and mem were both eligible and collided.
- It toggles to favour the unit that lost.
- Otherwise RR holds.

Slot update each cycle:
- First OR in {1, owner} at index LAT for each grant.
- Then shift right by one: S'[k] = S[k+1], and S'[SLOT_DEPTH-1] is cleared.

CDB select:
- `o_cdb_sel` is the one-hot decode of S[0].owner when S[0].vld is 1.
- Otherwise it is the decode of the LAT=0 grant made this cycle, if any.
- Otherwise it is 0.
- At most one bit is ever set. A second bit being set is an assertion failure.

Divider counter:
- A div grant loads DC with DIV_LAT.
- Otherwise DC decrements while nonzero.
- `o_div_busy` equals (DC != 0).

## Timing
- Grants are combinational from ready and the registered state. No grant is issued while `i_rst` is 1.
- A unit granted at cycle t owns the CDB at cycle t+LAT. With default parameters that is int/mem at t, mult at t+3, div at t+6.
- Div granted at t: `o_div_busy` is high during t+1 through t+DIV_LAT, and the next div grant is possible at t+DIV_LAT+1.
- Reset values: S all cleared, DC = 0, RR = 0. All outputs are 0 during the reset cycle and in the first cycle after reset until a grant occurs.
- Reset in mid-operation discards every pending reservation. Results already in flight must be squashed by the same reset in the functional units. No `o_cdb_sel` bit appears for them.
- A ready input that drops in the same cycle is honoured, since grants are not registered.

## Structure
- Shared package holds:
  - the `cdb_owner_e` enum (int, div, mult, mem),
  - the `cdb_slot_t` struct {vld, owner},
  - the default latency localparams, which the functional unit group also uses.
- One sub-module, `cdb_slot_shreg`: the SLOT_DEPTH-entry insert-then-shift register with owner decode to `o_cdb_sel`.
- Arbitration, RR and DC live in the top module.

## Test plan
- Reset, then all four ready in one cycle t: div, mult and int are granted and mem is denied. `o_cdb_sel` is 0001 at t, 0100 at t+3, 0010 at t+6. RR becomes 1.
- Only int and mem held ready for 6 cycles: grants alternate int, mem, int, mem, int, mem. `o_cdb_sel` alternates 0001 and 1000.
- Mult granted at t, int ready at t+3: int is denied at t+3 with `o_cdb_sel` = 0100. Int is granted at t+4 with `o_cdb_sel` = 0001.
- Div granted at t0, mult ready from t0+3: mult is denied at t0+3 because slot 3 is taken, and granted at t0+4. `o_cdb_sel` is 0010 at t0+6 and 0100 at t0+7.
- Div ready continuously: grants at t, t+7, t+14. `o_div_busy` is high exactly during t+1 through t+6.
- Mult granted at t, `i_rst` high at t+1: `o_cdb_sel` stays 0 through t+4 and `o_slot_vld` is 0 at t+2.

Source files
------------

// File: rtl/cdb_slot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_slot_arbiter_pkg
// Shared types and default latencies for the CDB slot arbiter and the
// functional unit group that must agree on result timing.
//   cdb_owner_e   : owner code of a CDB slot (int=0, div=1, mult=2, mem=3)
//   cdb_slot_t    : one reservation slot {vld, owner}
//   DEF_*_LAT     : default grant-to-CDB latencies
//   owner_onehot  : owner code to one-hot CDB select ({mem, mult, div, int})
// -----------------------------------------------------------------------------
package cdb_slot_arbiter_pkg;

   localparam int unsigned NUM_UNITS      = 4;
   localparam int unsigned DEF_INT_LAT    = 0;
   localparam int unsigned DEF_MEM_LAT    = 0;
   localparam int unsigned DEF_MULT_LAT   = 3;
   localparam int unsigned DEF_DIV_LAT    = 6;
   localparam int unsigned DEF_SLOT_DEPTH = 8;

   typedef enum logic [1:0] {
      OWN_INT  = 2'd0,
      OWN_DIV  = 2'd1,
      OWN_MULT = 2'd2,
      OWN_MEM  = 2'd3
   } cdb_owner_e;

   typedef struct packed {
      logic       vld;
      cdb_owner_e owner;
   } cdb_slot_t;

   // Bit position in the select equals the owner code.
   function automatic logic [NUM_UNITS-1:0] owner_onehot(input cdb_owner_e owner);
      owner_onehot = NUM_UNITS'(1) << owner;
   endfunction

endpackage

// File: rtl/cdb_slot_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_slot_arbiter_if
// Issue-ready / grant / CDB select bundle between the unit issue queues and
// the CDB slot arbiter.
//   i_ready_*  : issue queue holds an issuable entry       (master -> slave)
//   o_issue_*  : combinational grant                        (slave -> master)
//   o_cdb_sel  : one-hot CDB mux select {mem, mult, div, int}
//   o_div_busy : divider occupied
//   o_slot_vld : reservation valid bits (debug/coverage)
// -----------------------------------------------------------------------------
interface cdb_slot_arbiter_if #(
   parameter int unsigned SLOT_DEPTH = 8
);
   logic                  i_ready_int;
   logic                  i_ready_div;
   logic                  i_ready_mult;
   logic                  i_ready_mem;
   logic                  o_issue_int;
   logic                  o_issue_div;
   logic                  o_issue_mult;
   logic                  o_issue_mem;
   logic [3:0]            o_cdb_sel;
   logic                  o_div_busy;
   logic [SLOT_DEPTH-1:0] o_slot_vld;

   // Issue-queue side.
   modport master (
      output i_ready_int, i_ready_div, i_ready_mult, i_ready_mem,
      input  o_issue_int, o_issue_div, o_issue_mult, o_issue_mem,
      input  o_cdb_sel, o_div_busy, o_slot_vld
   );

   // Arbiter side.
   modport slave (
      input  i_ready_int, i_ready_div, i_ready_mult, i_ready_mem,
      output o_issue_int, o_issue_div, o_issue_mult, o_issue_mem,
      output o_cdb_sel, o_div_busy, o_slot_vld
   );
endinterface

// File: rtl/cdb_slot_shreg.sv
// -----------------------------------------------------------------------------
// cdb_slot_shreg
// SLOT_DEPTH-entry CDB reservation register. Each cycle the granted units are
// inserted at their latency index, then the whole register shifts toward
// slot 0. Slot 0 (or a zero-latency grant made this cycle) drives the select.
//   clk_i, rst_i : clock, synchronous active-high reset
//   grant_i      : grants this cycle, indexed by owner code
//   vld_o        : raw reservation valid bits (registered state)
//   cdb_sel_o    : one-hot CDB select {mem, mult, div, int}, zero in reset
// -----------------------------------------------------------------------------
module cdb_slot_shreg
   import cdb_slot_arbiter_pkg::*;
#(
   parameter int unsigned SLOT_DEPTH = DEF_SLOT_DEPTH,
   parameter int unsigned INT_LAT    = DEF_INT_LAT,
   parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
   parameter int unsigned MULT_LAT   = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT    = DEF_DIV_LAT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_UNITS-1:0]  grant_i,
   output logic [SLOT_DEPTH-1:0] vld_o,
   output logic [NUM_UNITS-1:0]  cdb_sel_o
);

   // Owners whose result lands on the CDB in the grant cycle itself.
   localparam logic [NUM_UNITS-1:0] LAT0_MASK = {
      (MEM_LAT == 0), (MULT_LAT == 0), (DIV_LAT == 0), (INT_LAT == 0)
   };

   cdb_slot_t [SLOT_DEPTH-1:0] slot_q;
   cdb_slot_t [SLOT_DEPTH-1:0] slot_d;
   cdb_slot_t [SLOT_DEPTH-1:0] slot_ins;

   // Insert this cycle's grants, then shift one slot toward the CDB.
   always_comb begin
      slot_ins = slot_q;
      slot_d   = '0;
      if (grant_i[OWN_INT])  slot_ins[INT_LAT]  = cdb_slot_t'{vld: 1'b1, owner: OWN_INT};
      if (grant_i[OWN_DIV])  slot_ins[DIV_LAT]  = cdb_slot_t'{vld: 1'b1, owner: OWN_DIV};
      if (grant_i[OWN_MULT]) slot_ins[MULT_LAT] = cdb_slot_t'{vld: 1'b1, owner: OWN_MULT};
      if (grant_i[OWN_MEM])  slot_ins[MEM_LAT]  = cdb_slot_t'{vld: 1'b1, owner: OWN_MEM};
      for (int k = 0; k < int'(SLOT_DEPTH) - 1; k++) begin
         slot_d[k] = slot_ins[k+1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) slot_q <= '0;
      else       slot_q <= slot_d;
   end

   always_comb begin
      vld_o = '0;
      for (int k = 0; k < int'(SLOT_DEPTH); k++) begin
         vld_o[k] = slot_q[k].vld;
      end
   end

   // Zero-latency grants only happen when slot 0 is free, so the two
   // sources never overlap.
   always_comb begin
      cdb_sel_o = '0;
      if (!rst_i) begin
         if (slot_q[0].vld) cdb_sel_o = owner_onehot(slot_q[0].owner);
         else               cdb_sel_o = grant_i & LAT0_MASK;
      end
   end

   ap_cdb_sel_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(cdb_sel_o))
      else $error("cdb_sel has more than one bit set: %b", cdb_sel_o);

endmodule

// File: rtl/cdb_slot_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_slot_arbiter
// Decides each cycle which functional-unit queues may issue so that no two
// results reach the CDB in the same cycle, and drives the CDB mux select.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : slave side of cdb_slot_arbiter_if (ready in; grants, CDB select,
//           divider busy and slot valid bits out)
// Grants are combinational from ready and registered state. Same-slot
// collisions resolve div > mult > int/mem, int vs mem by a round-robin bit.
// -----------------------------------------------------------------------------
module cdb_slot_arbiter
   import cdb_slot_arbiter_pkg::*;
#(
   parameter int unsigned INT_LAT    = DEF_INT_LAT,
   parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
   parameter int unsigned MULT_LAT   = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT    = DEF_DIV_LAT,
   parameter int unsigned SLOT_DEPTH = DEF_SLOT_DEPTH
) (
   input  logic          i_clk,
   input  logic          i_rst,
   cdb_slot_arbiter_if.slave bus
);

   localparam int unsigned DC_W = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;

   logic [SLOT_DEPTH-1:0] slot_vld;
   logic [NUM_UNITS-1:0]  grant;
   logic [NUM_UNITS-1:0]  cdb_sel;
   logic [DC_W-1:0]       dc_q, dc_d;
   logic                  rr_q, rr_d;
   logic                  elig_int, elig_div, elig_mult, elig_mem;
   logic                  gnt_int, gnt_div, gnt_mult, gnt_mem;

   // Eligibility: ready, target slot free, divider idle, not in reset.
   always_comb begin
      elig_int  = bus.i_ready_int  & ~slot_vld[INT_LAT]  & ~i_rst;
      elig_mem  = bus.i_ready_mem  & ~slot_vld[MEM_LAT]  & ~i_rst;
      elig_mult = bus.i_ready_mult & ~slot_vld[MULT_LAT] & ~i_rst;
      elig_div  = bus.i_ready_div  & ~slot_vld[DIV_LAT]  & (dc_q == '0) & ~i_rst;
   end

   // A unit loses only to a higher-priority eligible unit with the same latency.
   always_comb begin
      gnt_div  = elig_div;
      gnt_mult = elig_mult & ~(elig_div & (DIV_LAT == MULT_LAT));
      gnt_int  = elig_int
               & ~(elig_div  & (DIV_LAT  == INT_LAT))
               & ~(elig_mult & (MULT_LAT == INT_LAT))
               & ~(elig_mem  & (MEM_LAT  == INT_LAT) & rr_q);
      gnt_mem  = elig_mem
               & ~(elig_div  & (DIV_LAT  == MEM_LAT))
               & ~(elig_mult & (MULT_LAT == MEM_LAT))
               & ~(elig_int  & (INT_LAT  == MEM_LAT) & ~rr_q);
      grant    = {gnt_mem, gnt_mult, gnt_div, gnt_int};
   end

   // Round-robin flips on every int/mem collision, favouring the loser next.
   always_comb begin
      rr_d = rr_q;
      if (elig_int && elig_mem && (INT_LAT == MEM_LAT)) rr_d = ~rr_q;
   end

   // Divider countdown: busy from the cycle after grant for DIV_LAT cycles.
   always_comb begin
      dc_d = dc_q;
      if (gnt_div)          dc_d = DC_W'(DIV_LAT);
      else if (dc_q != '0)  dc_d = dc_q - DC_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_q <= 1'b0;
         dc_q <= '0;
      end else begin
         rr_q <= rr_d;
         dc_q <= dc_d;
      end
   end

   cdb_slot_shreg #(
      .SLOT_DEPTH (SLOT_DEPTH),
      .INT_LAT    (INT_LAT),
      .MEM_LAT    (MEM_LAT),
      .MULT_LAT   (MULT_LAT),
      .DIV_LAT    (DIV_LAT)
   ) u_shreg (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .grant_i   (grant),
      .vld_o     (slot_vld),
      .cdb_sel_o (cdb_sel)
   );

   // Registered state may be stale during the reset cycle, so mask it.
   assign bus.o_issue_int  = gnt_int;
   assign bus.o_issue_div  = gnt_div;
   assign bus.o_issue_mult = gnt_mult;
   assign bus.o_issue_mem  = gnt_mem;
   assign bus.o_cdb_sel    = cdb_sel;
   assign bus.o_div_busy   = ~i_rst & (dc_q != '0);
   assign bus.o_slot_vld   = i_rst ? '0 : slot_vld;

endmodule

// File: tb/tb_cdb_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_slot_arbiter
// Directed bench for cdb_slot_arbiter with default latencies
// (int/mem 0, mult 3, div 6, 8 slots). Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_slot_arbiter;

   localparam int unsigned SD = 8;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 i_clk = ~i_clk;

   cdb_slot_arbiter_if #(.SLOT_DEPTH(SD)) bus ();

   cdb_slot_arbiter #(
      .INT_LAT    (0),
      .MEM_LAT    (0),
      .MULT_LAT   (3),
      .DIV_LAT    (6),
      .SLOT_DEPTH (SD)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   // Grants packed {mem, mult, div, int}, same order as o_cdb_sel.
   logic [3:0] iss;
   assign iss = {bus.o_issue_mem, bus.o_issue_mult, bus.o_issue_div, bus.o_issue_int};

   // One cycle: drive reset and ready {mem, mult, div, int}, settle.
   task automatic cyc(input logic rst, input logic [3:0] rdy);
      @(negedge i_clk);
      i_rst            = rst;
      bus.i_ready_int  = rdy[0];
      bus.i_ready_div  = rdy[1];
      bus.i_ready_mult = rdy[2];
      bus.i_ready_mem  = rdy[3];
      #1;
   endtask

   task automatic do_reset;
      cyc(1'b1, 4'b0000);
      cyc(1'b1, 4'b0000);
   endtask

   task automatic test_reset;
      cyc(1'b1, 4'b1111);
      checks++;
      if (iss !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", iss); end
      checks++;
      if (bus.o_cdb_sel !== 4'b0000) begin errors++; $display("FAIL reset_cdb_sel: got %b expected 0000", bus.o_cdb_sel); end
      checks++;
      if (bus.o_slot_vld !== 8'h00 || bus.o_div_busy !== 1'b0) begin
         errors++; $display("FAIL reset_state: slot_vld %b busy %b expected 00000000 0", bus.o_slot_vld, bus.o_div_busy);
      end
      cyc(1'b1, 4'b1111);
      cyc(1'b0, 4'b0000);
      checks++;
      if ({iss, bus.o_cdb_sel, bus.o_div_busy, bus.o_slot_vld} !== 17'd0) begin
         errors++; $display("FAIL post_reset_idle: iss %b sel %b busy %b vld %b expected all 0",
                            iss, bus.o_cdb_sel, bus.o_div_busy, bus.o_slot_vld);
      end
   endtask

   task automatic test_all_ready;
      logic [3:0] exp_sel [0:6];
      do_reset();
      exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0000; exp_sel[2] = 4'b0000; exp_sel[3] = 4'b0100;
      exp_sel[4] = 4'b0000; exp_sel[5] = 4'b0000; exp_sel[6] = 4'b0010;
      for (int k = 0; k < 7; k++) begin
         cyc(1'b0, (k == 0) ? 4'b1111 : 4'b0000);
         if (k == 0) begin
            checks++;
            if (iss !== 4'b0111) begin errors++; $display("FAIL all_ready_grant: got %b expected 0111", iss); end
         end
         checks++;
         if (bus.o_cdb_sel !== exp_sel[k]) begin
            errors++; $display("FAIL all_ready_sel t+%0d: got %b expected %b", k, bus.o_cdb_sel, exp_sel[k]);
         end
      end
      // RR now favours mem.
      cyc(1'b0, 4'b1001);
      checks++;
      if (iss !== 4'b1000 || bus.o_cdb_sel !== 4'b1000) begin
         errors++; $display("FAIL all_ready_rr: iss %b sel %b expected 1000 1000", iss, bus.o_cdb_sel);
      end
   endtask

   task automatic test_int_mem_alternate;
      logic [3:0] exp;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 4'b1001);
         exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
         checks++;
         if (iss !== exp || bus.o_cdb_sel !== exp) begin
            errors++; $display("FAIL alternate cycle %0d: iss %b sel %b expected %b", k, iss, bus.o_cdb_sel, exp);
         end
      end
   endtask

   task automatic test_mult_blocks_int;
      do_reset();
      cyc(1'b0, 4'b0100);
      checks++;
      if (iss !== 4'b0100 || bus.o_cdb_sel !== 4'b0000) begin
         errors++; $display("FAIL mult_grant: iss %b sel %b expected 0100 0000", iss, bus.o_cdb_sel);
      end
      cyc(1'b0, 4'b0000);
      checks++;
      if (bus.o_slot_vld !== 8'b0000_0100) begin
         errors++; $display("FAIL mult_slot_vld: got %b expected 00000100", bus.o_slot_vld);
      end
      cyc(1'b0, 4'b0000);
      cyc(1'b0, 4'b0001);
      checks++;
      if (iss !== 4'b0000 || bus.o_cdb_sel !== 4'b0100) begin
         errors++; $display("FAIL int_denied: iss %b sel %b expected 0000 0100", iss, bus.o_cdb_sel);
      end
      cyc(1'b0, 4'b0001);
      checks++;
      if (iss !== 4'b0001 || bus.o_cdb_sel !== 4'b0001) begin
         errors++; $display("FAIL int_granted: iss %b sel %b expected 0001 0001", iss, bus.o_cdb_sel);
      end
   endtask

   task automatic test_div_blocks_mult;
      do_reset();
      cyc(1'b0, 4'b0010);
      checks++;
      if (iss !== 4'b0010) begin errors++; $display("FAIL div_grant: got %b expected 0010", iss); end
      cyc(1'b0, 4'b0000);
      cyc(1'b0, 4'b0000);
      cyc(1'b0, 4'b0100);
      checks++;
      if (iss !== 4'b0000 || bus.o_div_busy !== 1'b1) begin
         errors++; $display("FAIL mult_denied: iss %b busy %b expected 0000 1", iss, bus.o_div_busy);
      end
      cyc(1'b0, 4'b0100);
      checks++;
      if (iss !== 4'b0100) begin errors++; $display("FAIL mult_after_div: got %b expected 0100", iss); end
      cyc(1'b0, 4'b0000);
      checks++;
      if (bus.o_cdb_sel !== 4'b0000) begin errors++; $display("FAIL gap_sel t0+5: got %b expected 0000", bus.o_cdb_sel); end
      cyc(1'b0, 4'b0000);
      checks++;
      if (bus.o_cdb_sel !== 4'b0010) begin errors++; $display("FAIL div_sel t0+6: got %b expected 0010", bus.o_cdb_sel); end
      cyc(1'b0, 4'b0000);
      checks++;
      if (bus.o_cdb_sel !== 4'b0100) begin errors++; $display("FAIL mult_sel t0+7: got %b expected 0100", bus.o_cdb_sel); end
   endtask

   task automatic test_back_to_back_div;
      logic       exp_gnt;
      logic       exp_busy;
      logic [3:0] exp_sel;
      do_reset();
      for (int k = 0; k < 15; k++) begin
         cyc(1'b0, 4'b0010);
         exp_gnt  = (k % 7 == 0);
         exp_busy = (k % 7 != 0);
         exp_sel  = (k % 7 == 6) ? 4'b0010 : 4'b0000;
         checks++;
         if (iss !== {2'b00, exp_gnt, 1'b0} || bus.o_div_busy !== exp_busy) begin
            errors++; $display("FAIL div_b2b t+%0d: iss %b busy %b expected %b %b",
                               k, iss, bus.o_div_busy, {2'b00, exp_gnt, 1'b0}, exp_busy);
         end
         checks++;
         if (bus.o_cdb_sel !== exp_sel) begin
            errors++; $display("FAIL div_b2b_sel t+%0d: got %b expected %b", k, bus.o_cdb_sel, exp_sel);
         end
      end
   endtask

   task automatic test_mid_reset;
      do_reset();
      cyc(1'b0, 4'b0100);
      checks++;
      if (iss !== 4'b0100) begin errors++; $display("FAIL mid_reset_mult: got %b expected 0100", iss); end
      cyc(1'b1, 4'b1111);
      checks++;
      if (iss !== 4'b0000 || bus.o_cdb_sel !== 4'b0000 || bus.o_slot_vld !== 8'h00) begin
         errors++; $display("FAIL mid_reset_cycle: iss %b sel %b vld %b expected 0000 0000 00000000",
                            iss, bus.o_cdb_sel, bus.o_slot_vld);
      end
      for (int k = 2; k <= 4; k++) begin
         cyc(1'b0, 4'b0000);
         checks++;
         if (bus.o_cdb_sel !== 4'b0000 || bus.o_slot_vld !== 8'h00) begin
            errors++; $display("FAIL mid_reset_squash t+%0d: sel %b vld %b expected 0000 00000000",
                               k, bus.o_cdb_sel, bus.o_slot_vld);
         end
      end
   endtask

   initial begin
      bus.i_ready_int  = 1'b0;
      bus.i_ready_div  = 1'b0;
      bus.i_ready_mult = 1'b0;
      bus.i_ready_mem  = 1'b0;
      test_reset();
      test_all_ready();
      test_int_mem_alternate();
      test_mult_blocks_int();
      test_div_blocks_mult();
      test_back_to_back_div();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
